// File: rtl/motor_sequencer_pkg.sv
// Shared types for the motor sequencer: FSM state encoding, H-bridge
// drive patterns and a small sizing helper.
package motor_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DEAD  = 2'd1,
      ST_TURN  = 2'd2,
      ST_DRIVE = 2'd3
   } state_t;

   typedef struct packed {
      logic l_fwd;
      logic l_rev;
      logic r_fwd;
      logic r_rev;
   } bridge_t;

   // In-place right turn spins left wheel forward, right wheel backward.
   localparam bridge_t BR_OFF   = 4'b0000;
   localparam bridge_t BR_TURN  = 4'b1001;
   localparam bridge_t BR_DRIVE = 4'b1010;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/motor_sequencer_if.sv
// Command handshake from the decision FSM plus bridge drive and status
// returned by the sequencer.
interface motor_sequencer_if;
   logic cmd_valid;
   logic front;
   logic rotate;
   logic stop;
   logic cmd_ready;
   logic l_fwd;
   logic l_rev;
   logic r_fwd;
   logic r_rev;
   logic done;
   logic aborted;

   modport master (
      output cmd_valid, front, rotate, stop,
      input  cmd_ready, l_fwd, l_rev, r_fwd, r_rev, done, aborted
   );

   modport slave (
      input  cmd_valid, front, rotate, stop,
      output cmd_ready, l_fwd, l_rev, r_fwd, r_rev, done, aborted
   );
endinterface

// File: rtl/motor_sequencer_pwm_gate.sv
// PWM gate: period counter with restart, producing the enable that the
// next clock's registered bridge outputs will carry.
module pwm_gate #(
   parameter int unsigned PWM_PERIOD = 4,
   parameter int unsigned PWM_DUTY   = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,   // next cycle is a motion cycle
   input  logic restart,  // next cycle is the first of a motion phase
   output logic en        // PWM enable for the next cycle
);
   localparam int unsigned CW = $clog2(PWM_PERIOD + 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   // Next count: held at zero outside motion, zero on phase entry, else wrap.
   always_comb begin
      cnt_nxt = '0;
      if (active && !restart)
         cnt_nxt = (cnt == CW'(PWM_PERIOD - 1)) ? '0 : cnt + 1'b1;
      en = active && (cnt_nxt < CW'(PWM_DUTY));
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_nxt;
   end
endmodule

// File: rtl/motor_sequencer.sv
// Motor sequencer: turns one front/rotate decision into dead-time guarded,
// PWM-gated H-bridge drive and reports done/aborted back to the decision FSM.
module motor_sequencer
   import motor_sequencer_pkg::*;
#(
   parameter int unsigned MOVE_CYCLES = 8,
   parameter int unsigned TURN_CYCLES = 6,
   parameter int unsigned DEAD_CYCLES = 2,
   parameter int unsigned PWM_PERIOD  = 4,
   parameter int unsigned PWM_DUTY    = 3
) (
   input  logic              initial_clk,
   input  logic              rst_n,
   motor_sequencer_if.slave  bus
);
   localparam int unsigned PH_W = $clog2(max3(MOVE_CYCLES, TURN_CYCLES, DEAD_CYCLES) + 1);

   state_t          state, state_nxt;
   logic [PH_W-1:0] phase_cnt, phase_nxt;
   logic            rot_q, rot_nxt;
   logic            front_q, front_nxt;
   logic            abort_q, abort_nxt;   // stop seen; current DEAD ends as abort
   logic            done_nxt, aborted_nxt;
   logic            accept, ph_last;
   logic            motion_nxt, pwm_restart, pwm_en;
   bridge_t         br_q, br_nxt;
   logic            done_q, aborted_q;

   // Ready follows stop directly so a held stop blocks acceptance at once.
   assign bus.cmd_ready = (state == ST_IDLE) & ~bus.stop;
   assign accept        = bus.cmd_valid & bus.cmd_ready;

   // Terminal count of the current phase.
   always_comb begin
      ph_last = 1'b0;
      case (state)
         ST_DEAD:  ph_last = (phase_cnt == PH_W'(DEAD_CYCLES - 1));
         ST_TURN:  ph_last = (phase_cnt == PH_W'(TURN_CYCLES - 1));
         ST_DRIVE: ph_last = (phase_cnt == PH_W'(MOVE_CYCLES - 1));
         default:  ph_last = 1'b0;
      endcase
   end

   // Next-state, command latch and completion pulses.
   always_comb begin
      state_nxt   = state;
      rot_nxt     = rot_q;
      front_nxt   = front_q;
      abort_nxt   = abort_q;
      done_nxt    = 1'b0;
      aborted_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               rot_nxt   = bus.rotate;
               front_nxt = bus.front;
               abort_nxt = 1'b0;
               if (!bus.rotate && !bus.front) done_nxt  = 1'b1;
               else                           state_nxt = ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (bus.stop) abort_nxt = 1'b1;
            if (ph_last) begin
               if (abort_nxt) begin
                  state_nxt   = ST_IDLE;
                  aborted_nxt = 1'b1;
               end else if (rot_q) begin
                  state_nxt = ST_TURN;
               end else begin
                  state_nxt = ST_DRIVE;
               end
            end
         end
         ST_TURN: begin
            if (bus.stop) begin
               state_nxt = ST_DEAD;
               abort_nxt = 1'b1;
            end else if (ph_last) begin
               if (front_q) begin
                  // Turn done; the following DEAD must lead into DRIVE.
                  state_nxt = ST_DEAD;
                  rot_nxt   = 1'b0;
               end else begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         ST_DRIVE: begin
            if (bus.stop) begin
               state_nxt = ST_DEAD;
               abort_nxt = 1'b1;
            end else if (ph_last) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Phase counter restarts on every state change and idles at zero.
   always_comb begin
      phase_nxt = '0;
      if (state_nxt == state && state != ST_IDLE)
         phase_nxt = phase_cnt + 1'b1;
   end

   assign motion_nxt  = (state_nxt == ST_TURN) || (state_nxt == ST_DRIVE);
   assign pwm_restart = motion_nxt && (state_nxt != state);

   pwm_gate #(
      .PWM_PERIOD (PWM_PERIOD),
      .PWM_DUTY   (PWM_DUTY)
   ) u_pwm (
      .clk     (initial_clk),
      .rst_n   (rst_n),
      .active  (motion_nxt),
      .restart (pwm_restart),
      .en      (pwm_en)
   );

   // Bridge pattern for the next cycle, gated by PWM.
   always_comb begin
      br_nxt = BR_OFF;
      case (state_nxt)
         ST_TURN:  br_nxt = bridge_t'(BR_TURN  & {4{pwm_en}});
         ST_DRIVE: br_nxt = bridge_t'(BR_DRIVE & {4{pwm_en}});
         default:  br_nxt = BR_OFF;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge initial_clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         phase_cnt <= '0;
         rot_q     <= 1'b0;
         front_q   <= 1'b0;
         abort_q   <= 1'b0;
         br_q      <= BR_OFF;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         phase_cnt <= phase_nxt;
         rot_q     <= rot_nxt;
         front_q   <= front_nxt;
         abort_q   <= abort_nxt;
         br_q      <= br_nxt;
         done_q    <= done_nxt;
         aborted_q <= aborted_nxt;
      end
   end

   assign bus.l_fwd   = br_q.l_fwd;
   assign bus.l_rev   = br_q.l_rev;
   assign bus.r_fwd   = br_q.r_fwd;
   assign bus.r_rev   = br_q.r_rev;
   assign bus.done    = done_q;
   assign bus.aborted = aborted_q;
endmodule

// File: tb/tb_motor_sequencer.sv
// Self-checking bench for motor_sequencer: directed scenarios plus random
// commands and stop pulses against a timeline model of the command rules.
module tb_motor_sequencer;
   localparam int MOVE = 8, TURN = 6, DEAD = 2, PER = 4, DUTY = 3;

   logic initial_clk = 1'b0;
   logic rst_n       = 1'b0;
   int   n_checks    = 0;
   int   n_errors    = 0;
   logic [5:0] exp_q[$];   // {l_fwd,l_rev,r_fwd,r_rev,done,aborted} per cycle

   motor_sequencer_if bus();

   motor_sequencer #(
      .MOVE_CYCLES (MOVE),
      .TURN_CYCLES (TURN),
      .DEAD_CYCLES (DEAD),
      .PWM_PERIOD  (PER),
      .PWM_DUTY    (DUTY)
   ) dut (
      .initial_clk (initial_clk),
      .rst_n       (rst_n),
      .bus         (bus)
   );

   always #5 initial_clk = ~initial_clk;

   function automatic logic [5:0] act();
      return {bus.l_fwd, bus.l_rev, bus.r_fwd, bus.r_rev, bus.done, bus.aborted};
   endfunction

   // Expected timeline, one entry per cycle after acceptance: phases as a
   // list of segments, PWM from the position within a segment, stop cuts it.
   task automatic build_exp(input bit rot, input bit fr, input int stop_at);
      int segs[$];
      int cyc, len, extra;
      logic [3:0] pat;
      exp_q.delete();
      if (!rot && !fr) begin
         exp_q.push_back(6'b000010);
         return;
      end
      segs.push_back(0);
      if (rot)        segs.push_back(1);
      if (rot && fr)  segs.push_back(0);
      if (fr)         segs.push_back(2);
      cyc = 1;
      foreach (segs[s]) begin
         len = (segs[s] == 0) ? DEAD : (segs[s] == 1) ? TURN : MOVE;
         pat = (segs[s] == 1) ? 4'b1001 : (segs[s] == 2) ? 4'b1010 : 4'b0000;
         for (int i = 0; i < len; i++) begin
            exp_q.push_back({((i % PER) < DUTY) ? pat : 4'b0000, 2'b00});
            if (cyc == stop_at) begin
               extra = (segs[s] == 0) ? len - 1 - i : DEAD;
               for (int k = 0; k < extra; k++) exp_q.push_back(6'b000000);
               exp_q.push_back(6'b000001);
               return;
            end
            cyc++;
         end
      end
      exp_q.push_back(6'b000010);
   endtask

   // Issue a command in the current (idle) cycle and follow it to done/aborted.
   task automatic run_cmd(input bit rot, input bit fr, input int stop_at,
                          input bit hold, input string tag);
      int n;
      bit stop_drv;
      build_exp(rot, fr, stop_at);
      n = exp_q.size();
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL %s ready_at_issue: got %b want 1", tag, bus.cmd_ready);
      end
      bus.cmd_valid = 1'b1;
      bus.rotate    = rot;
      bus.front     = fr;
      stop_drv      = 1'b0;
      for (int c = 1; c <= n; c++) begin
         @(posedge initial_clk); #1;
         n_checks++;
         if (act() !== exp_q[c-1]) begin
            n_errors++;
            $display("FAIL %s outputs cyc%0d: got %b want %b", tag, c, act(), exp_q[c-1]);
         end
         n_checks++;
         if (bus.cmd_ready !== ((c == n) && !stop_drv)) begin
            n_errors++;
            $display("FAIL %s cmd_ready cyc%0d: got %b want %b", tag, c, bus.cmd_ready,
                     ((c == n) && !stop_drv));
         end
         n_checks++;
         if (((bus.l_fwd & bus.l_rev) | (bus.r_fwd & bus.r_rev) | (bus.done & bus.aborted)) !== 1'b0) begin
            n_errors++;
            $display("FAIL %s exclusive cyc%0d: got %b want 0", tag, c, act());
         end
         stop_drv = hold ? (stop_at > 0 && c >= stop_at) : (c == stop_at);
         bus.stop = stop_drv;
         if (c < n) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.rotate    = 1'($urandom_range(0, 1));
            bus.front     = 1'($urandom_range(0, 1));
         end else begin
            bus.cmd_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge initial_clk);
      #1;
      n_checks++;
      if (act() !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b want 000000", act());
      end
      rst_n = 1'b1;
      @(posedge initial_clk); #1;
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || act() !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_release: got ready=%b out=%b want ready=1 out=000000",
                  bus.cmd_ready, act());
      end
   endtask

   task automatic test_drive();      run_cmd(1'b0, 1'b1, 0, 1'b0, "drive");      endtask
   task automatic test_turn_drive(); run_cmd(1'b1, 1'b1, 0, 1'b0, "turn_drive"); endtask
   task automatic test_noop();       run_cmd(1'b0, 1'b0, 0, 1'b0, "noop");       endtask

   // Stop held from cycle 5 of a drive, then stop in IDLE blocks acceptance.
   task automatic test_stop_held();
      run_cmd(1'b0, 1'b1, 5, 1'b1, "stop_held");
      bus.cmd_valid = 1'b1;
      bus.front     = 1'b1;
      bus.rotate    = 1'b0;
      repeat (3) begin
         @(posedge initial_clk); #1;
         n_checks++;
         if (act() !== 6'b0 || bus.cmd_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_idle_block: got ready=%b out=%b want ready=0 out=000000",
                     bus.cmd_ready, act());
         end
      end
      bus.cmd_valid = 1'b0;
      bus.stop      = 1'b0;
      @(posedge initial_clk); #1;
      n_checks++;
      if (act() !== 6'b0 || bus.cmd_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL stop_release: got ready=%b out=%b want ready=1 out=000000",
                  bus.cmd_ready, act());
      end
   endtask

   task automatic test_reset_mid();
      build_exp(1'b1, 1'b1, 0);
      bus.cmd_valid = 1'b1;
      bus.rotate    = 1'b1;
      bus.front     = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge initial_clk); #1;
         bus.cmd_valid = 1'b0;
         n_checks++;
         if (act() !== exp_q[c-1]) begin
            n_errors++;
            $display("FAIL reset_mid_pre cyc%0d: got %b want %b", c, act(), exp_q[c-1]);
         end
      end
      rst_n = 1'b0;
      @(posedge initial_clk); #1;
      n_checks++;
      if (act() !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_mid_clear: got %b want 000000", act());
      end
      rst_n = 1'b1;
      @(posedge initial_clk); #1;
      run_cmd(1'b0, 1'b1, 0, 1'b0, "post_reset");
   endtask

   task automatic test_back_to_back();
      run_cmd(1'b0, 1'b1, 0, 1'b0, "b2b_0");
      run_cmd(1'b1, 1'b0, 0, 1'b0, "b2b_1");
      run_cmd(1'b0, 1'b0, 0, 1'b0, "b2b_2");
      run_cmd(1'b1, 1'b1, 0, 1'b0, "b2b_3");
   endtask

   task automatic test_random();
      bit rot, fr;
      int busy, stop_at, gap;
      for (int it = 0; it < 40; it++) begin
         rot = 1'($urandom_range(0, 1));
         fr  = 1'($urandom_range(0, 1));
         build_exp(rot, fr, 0);
         busy    = exp_q.size() - 1;
         stop_at = (busy > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, busy)) : 0;
         run_cmd(rot, fr, stop_at, 1'b0, "random");
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            @(posedge initial_clk); #1;
            n_checks++;
            if (act() !== 6'b0 || bus.cmd_ready !== 1'b1) begin
               n_errors++;
               $display("FAIL random_gap it%0d: got ready=%b out=%b want ready=1 out=000000",
                        it, bus.cmd_ready, act());
            end
         end
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.front     = 1'b0;
      bus.rotate    = 1'b0;
      bus.stop      = 1'b0;
      test_reset();
      test_drive();
      test_turn_drive();
      test_noop();
      test_stop_held();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
